fp_mul_arbiter: RTL and testbench

Round-robin arbiter that shares one single_multiplier instance between NUM_REQ requesters. Each granted operation is sequenced through the multiplier's a/b/z stb-ack handshake. The result is returned on a single shared response channel tagged with the requester ID. It sits between the compute clients and the multiplier; the multiplier's own ports connect directly to the mul_* ports.

---
 rtl/fp_mul_pkg.sv | 22 ++
 rtl/rr_grant.sv | 28 ++
 rtl/fp_mul_arbiter.sv | 123 ++++++++++++
 tb/tb_fp_mul_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared FSM encoding, IEEE-754 constants and width helper for the multiplier arbiter.
package fp_mul_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEND_A = 3'd1,
        SEND_B = 3'd2,
        WAIT_Z = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic [31:0] FP_QNAN     = 32'hFFC00000;
    localparam logic [31:0] FP_POS_ZERO = 32'h00000000;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// rr_grant: combinational round-robin picker, first set request at or after ptr (wrapping) wins.
module rr_grant #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);

    // Scan offsets from farthest to nearest so the closest request to ptr is the last write.
    always_comb begin
        int j;
        j = 0;
        gnt = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                gnt = '0;
                gnt[j] = 1'b1;
                idx = W'(j);
            end
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: shares one single_multiplier between NUM_REQ requesters via its a/b/z stb-ack handshake.
// Define FP_MUL_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module fp_mul_arbiter
    import fp_mul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  resp_valid,
    output logic [31:0]           resp_z,
    output logic [ID_W-1:0]       resp_id,
    input  logic                  resp_ready,
    output logic [31:0]           mul_a,
    output logic                  mul_a_stb,
    input  logic                  mul_a_ack,
    output logic [31:0]           mul_b,
    output logic                  mul_b_stb,
    input  logic                  mul_b_ack,
    input  logic [31:0]           mul_z,
    input  logic                  mul_z_stb,
    output logic                  mul_z_ack
);

    if (ID_W != clog2(NUM_REQ)) begin : g_bad_id_w
        $error("ID_W must equal clog2(NUM_REQ)");
    end

    state_t            state, state_nx;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]   gnt_idx;
    logic [ID_W-1:0]   id_q;
    logic              take;
    logic              z_fire;

`ifdef FP_MUL_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt = '0;
        gnt_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                gnt = '0;
                gnt[i] = 1'b1;
                gnt_idx = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0] rr_ptr;

    rr_grant #(.N(NUM_REQ), .W(ID_W)) u_rr_grant (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rr_ptr <= '0;
        else if (take)
            rr_ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
`endif

    assign take      = (state == IDLE) && |req_valid;
    assign z_fire    = mul_z_stb && mul_z_ack;
    assign req_ready = (state == IDLE) ? gnt : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = take ? SEND_A : IDLE;
            SEND_A:  state_nx = (mul_a_stb && mul_a_ack) ? SEND_B : SEND_A;
            SEND_B:  state_nx = (mul_b_stb && mul_b_ack) ? WAIT_Z : SEND_B;
            WAIT_Z:  state_nx = z_fire ? RESP : WAIT_Z;
            RESP:    state_nx = resp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs are flops decoded from the next state, so they track the state exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_a_stb  <= 1'b0;
            mul_b_stb  <= 1'b0;
            mul_z_ack  <= 1'b0;
            resp_valid <= 1'b0;
            mul_a      <= FP_POS_ZERO;
            mul_b      <= FP_POS_ZERO;
            id_q       <= '0;
            resp_z     <= FP_POS_ZERO;
            resp_id    <= '0;
        end else begin
            mul_a_stb  <= state_nx == SEND_A;
            mul_b_stb  <= state_nx == SEND_B;
            mul_z_ack  <= state_nx == WAIT_Z;
            resp_valid <= state_nx == RESP;
            if (take) begin
                mul_a <= req_a[32*gnt_idx +: 32];
                mul_b <= req_b[32*gnt_idx +: 32];
                id_q  <= gnt_idx;
            end
            if (state == WAIT_Z && z_fire) begin
                resp_z  <= mul_z;
                resp_id <= id_q;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb_fp_mul_arbiter: directed bench with a behavioural multiplier stub on the mul_* handshake.
module tb_fp_mul_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [127:0] req_a = '0;
    logic [127:0] req_b = '0;
    logic [3:0]   req_ready;
    logic         resp_valid;
    logic [31:0]  resp_z;
    logic [1:0]   resp_id;
    logic         resp_ready = 1'b1;
    logic [31:0]  mul_a, mul_b, mul_z;
    logic         mul_a_stb, mul_a_ack, mul_b_stb, mul_b_ack, mul_z_stb, mul_z_ack;

    int n_tests = 0;
    int n_fail = 0;

    logic [31:0] rz_q[$];
    logic [1:0]  rid_q[$];
    logic [1:0]  gid_q[$];
    int          gcnt[4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    fp_mul_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_z     (resp_z),
        .resp_id    (resp_id),
        .resp_ready (resp_ready),
        .mul_a      (mul_a),
        .mul_a_stb  (mul_a_stb),
        .mul_a_ack  (mul_a_ack),
        .mul_b      (mul_b),
        .mul_b_stb  (mul_b_stb),
        .mul_b_ack  (mul_b_ack),
        .mul_z      (mul_z),
        .mul_z_stb  (mul_z_stb),
        .mul_z_ack  (mul_z_ack)
    );

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40000000, 32'h40400000}: return 32'h40C00000;
            {32'h3FC00000, 32'h3FC00000}: return 32'h40100000;
            {32'h7F800000, 32'h00000000}: return 32'hFFC00000;
            {32'hC0000000, 32'h40800000}: return 32'hC1000000;
            default:                      return 32'hDEADBEEF;
        endcase
    endfunction

    logic [1:0]  ms;
    logic [31:0] ma, mb;
    int          mc;

    // Multiplier stub: ack A, ack B, compute a few cycles, present Z until acked; shares rst.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ms <= 0; mc <= 0; ma <= 0; mb <= 0; mul_z <= 0;
            mul_a_ack <= 0; mul_b_ack <= 0; mul_z_stb <= 0;
        end else begin
            case (ms)
                2'd0: begin
                    mul_a_ack <= 1'b1;
                    if (mul_a_ack && mul_a_stb) begin ma <= mul_a; mul_a_ack <= 1'b0; ms <= 2'd1; end
                end
                2'd1: begin
                    mul_b_ack <= 1'b1;
                    if (mul_b_ack && mul_b_stb) begin mb <= mul_b; mul_b_ack <= 1'b0; ms <= 2'd2; mc <= 0; end
                end
                2'd2: begin
                    mc <= mc + 1;
                    if (mc == 2) begin mul_z <= fmul(ma, mb); mul_z_stb <= 1'b1; ms <= 2'd3; end
                end
                default: if (mul_z_stb && mul_z_ack) begin mul_z_stb <= 1'b0; ms <= 2'd0; end
            endcase
        end
    end

    always @(negedge clk) begin
        if (resp_valid && resp_ready) begin
            rz_q.push_back(resp_z);
            rid_q.push_back(resp_id);
        end
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                gcnt[i] = gcnt[i] + 1;
                gid_q.push_back(2'(i));
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Raise the masked requests and drop each one the cycle after its grant.
    task automatic serve(input logic [3:0] m);
        int k;
        logic [3:0] g;
        k = 0;
        @(posedge clk); #1 req_valid = m;
        while (req_valid != 0 && k < 1000) begin
            @(negedge clk);
            k++;
            g = req_valid & req_ready;
            if (g != 0) begin
                @(posedge clk); #1 req_valid = req_valid & ~g;
            end
        end
        check("serve_done", 64'(req_valid), 64'h0);
    endtask

    task automatic wait_resp(input int n);
        int k;
        k = 0;
        while (rz_q.size() < n && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("resp_count", 64'(rz_q.size()), 64'(n));
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {mul_a, mul_b}, 64'h0);
        check(tag, 64'({resp_valid, mul_a_stb, mul_b_stb, mul_z_ack, resp_id, resp_z}), 64'h0);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        check("reset_ready", 64'(req_ready), 64'h0);
        @(negedge clk); #1 rst = 1'b1;

        req_a = {4{32'h3FC00000}};
        req_b = {4{32'h3FC00000}};
        serve(4'b1111);
        wait_resp(4);
        for (int i = 0; i < 4; i++) begin
            check("rr1_id", 64'(rid_q[i]), 64'(i));
            check("rr1_z", 64'(rz_q[i]), 64'h40100000);
        end
        serve(4'b1111);
        wait_resp(8);
        for (int i = 4; i < 8; i++) check("rr2_id", 64'(rid_q[i]), 64'(i - 4));

        rz_q.delete(); rid_q.delete();
        gcnt = '{0, 0, 0, 0};
        req_a[31:0] = 32'h40000000;
        req_b[31:0] = 32'h40400000;
        serve(4'b0001);
        wait_resp(1);
        check("single_z", 64'(rz_q[0]), 64'h40C00000);
        check("single_id", 64'(rid_q[0]), 64'h0);
        check("single_grants", 64'(gcnt[0] * 16 + gcnt[1] + gcnt[2] + gcnt[3]), 64'h10);

        req_a[63:32] = 32'h7F800000; req_b[63:32] = 32'h00000000;
        req_a[95:64] = 32'hC0000000; req_b[95:64] = 32'h40800000;
        serve(4'b0010);
        serve(4'b0100);
        wait_resp(3);
        check("inf_zero_z", 64'(rz_q[1]), 64'hFFC00000);
        check("inf_zero_id", 64'(rid_q[1]), 64'h1);
        check("neg_z", 64'(rz_q[2]), 64'hC1000000);
        check("neg_id", 64'(rid_q[2]), 64'h2);

        @(posedge clk); #1 resp_ready = 1'b0;
        serve(4'b0001);
        k = 0;
        while (!resp_valid && k < 200) begin @(negedge clk); k++; end
        check("bp_valid", 64'(resp_valid), 64'h1);
        @(posedge clk); #1 req_valid = 4'b1110;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_hold", {27'h0, resp_valid, resp_z, resp_id, req_ready}, {27'h0, 1'b1, 32'h40C00000, 2'd0, 4'h0});
        end
        check("bp_no_grant", 64'(gcnt[1] + gcnt[2] + gcnt[3]), 64'h2);
        req_valid = 4'b0000;
        resp_ready = 1'b1;
        wait_resp(4);
        check("bp_z", 64'(rz_q[3]), 64'h40C00000);

        serve(4'b0001);
        k = 0;
        while (!mul_z_ack && k < 200) begin @(negedge clk); k++; end
        check("wz_reached", 64'(mul_z_ack), 64'h1);
        #2 rst = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk); #1 rst = 1'b1;
        check("reset_drop", 64'(rz_q.size()), 64'h4);
        serve(4'b0001);
        wait_resp(5);
        check("post_reset_z", 64'(rz_q[4]), 64'h40C00000);
        check("post_reset_id", 64'(rid_q[4]), 64'h0);

`ifdef FP_MUL_ARB_FIXED_PRIO_EN
        gid_q.delete();
        @(posedge clk); #1 req_valid = 4'b1001;
        k = 0;
        while (gid_q.size() < 4 && k < 1000) begin @(negedge clk); k++; end
        @(posedge clk); #1 req_valid = 4'b0000;
        check("fixed_count", 64'(gid_q.size() >= 4), 64'h1);
        for (int i = 0; i < 4 && i < gid_q.size(); i++) check("fixed_id", 64'(gid_q[i]), 64'h0);
`endif

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
